// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, instruction buffer, redirect and misaligned-redirect fault.
// Define FETCH_PREFETCH_EN for a DEPTH-entry prefetch FIFO; default build uses a single-entry buffer.
module fetch_unit #(
   parameter logic [6:0]  RESET_PC = 7'd4,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [6:0]  rom_addr,
   output logic        rom_en,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [6:0]  redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [6:0]  instr_pc,
   output logic        fault
);

`ifdef FETCH_PREFETCH_EN
   localparam int unsigned BufDepth = (DEPTH < 1) ? 1 : DEPTH;
`else
   localparam int unsigned BufDepth = 1;
`endif
   localparam int unsigned PtrW  = (BufDepth > 1) ? $clog2(BufDepth) : 1;
   localparam int unsigned Slots = 1 << PtrW;
   localparam int unsigned CntW  = $clog2(BufDepth + 1);

   typedef enum logic [1:0] {StFetch, StStall, StFault} state_e;

   state_e            state_q;
   logic [6:0]        pc_q;
   logic              fault_q;
   logic [CntW-1:0]   cnt_q;
   logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [31:0]       data_q [Slots];
   logic [6:0]        addr_q [Slots];

   logic buf_full;
   logic pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(BufDepth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      buf_full    = (cnt_q == CntW'(BufDepth));
      instr_valid = (cnt_q != '0);
      pop         = instr_valid && instr_ready;
      // A full buffer may still fetch when its head leaves in the same cycle.
      rom_en      = rst_n && (state_q == StFetch) && !redirect_valid && (!buf_full || pop);
      rom_addr    = pc_q;
      instr       = instr_valid ? data_q[rd_ptr_q] : '0;
      instr_pc    = instr_valid ? addr_q[rd_ptr_q] : '0;
      fault       = fault_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StFetch;
         pc_q     <= RESET_PC;
         fault_q  <= 1'b0;
         cnt_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < Slots; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else if (state_q != StFault) begin
         if (redirect_valid) begin
            // Redirect wins over everything, including a same-cycle pop.
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
               state_q <= StFault;
               fault_q <= 1'b1;
            end else begin
               pc_q    <= redirect_pc;
               state_q <= StFetch;
            end
         end else begin
            if (pop) begin
               rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (rom_en) begin
               data_q[wr_ptr_q] <= rom_data;
               addr_q[wr_ptr_q] <= pc_q;
               wr_ptr_q         <= ptr_inc(wr_ptr_q);
               pc_q             <= pc_q + 7'd4;
            end
            case ({rom_en, pop})
               2'b10:   cnt_q <= cnt_q + 1'b1;
               2'b01:   cnt_q <= cnt_q - 1'b1;
               default: cnt_q <= cnt_q;
            endcase
            if (state_q == StFetch && !rom_en) begin
               state_q <= StStall;
            end else if (state_q == StStall && pop) begin
               state_q <= StFetch;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

   localparam logic [6:0] ResetPc = 7'd4;
`ifdef FETCH_PREFETCH_EN
   localparam int ModelDepth = 2;
`else
   localparam int ModelDepth = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  rom_addr;
   logic        rom_en;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [6:0]  redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [6:0]  instr_pc;
   logic        fault;

   logic [31:0] rom [32];
   assign rom_data = rom[rom_addr[6:2]];

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (ResetPc),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_en         (rom_en),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .fault          (fault)
   );

   typedef struct {
      logic [6:0]  pc;
      logic [31:0] data;
   } entry_t;

   entry_t     q[$];
   logic [6:0] m_pc;
   bit         m_stall;
   bit         m_fault;
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_rom_en", rom_en, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
      check("rst_fault", fault, 0);
      q.delete();
      m_pc    = ResetPc;
      m_stall = 0;
      m_fault = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step(input bit ready, input bit rv, input logic [6:0] rpc);
      bit          vld, pop, full, en;
      logic [31:0] exp_instr;
      logic [6:0]  exp_pc;
      entry_t      e;
      instr_ready    = ready;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      vld  = !m_fault && (q.size() != 0);
      pop  = vld && ready;
      full = (q.size() >= ModelDepth);
      en   = !m_fault && !m_stall && !rv && (!full || pop);
      exp_instr = '0;
      exp_pc    = '0;
      if (vld) begin
         exp_instr = q[0].data;
         exp_pc    = q[0].pc;
      end
      check("instr_valid", instr_valid, vld);
      check("instr", instr, exp_instr);
      check("instr_pc", instr_pc, exp_pc);
      check("rom_en", rom_en, en);
      if (en) check("rom_addr", rom_addr, m_pc);
      check("fault", fault, m_fault);
      if (!m_fault) begin
         if (rv) begin
            q.delete();
            if (rpc[1:0] != 2'b00) begin
               m_fault = 1;
            end else begin
               m_pc    = rpc;
               m_stall = 0;
            end
         end else begin
            if (pop) void'(q.pop_front());
            if (m_stall) begin
               if (pop) m_stall = 0;
            end else if (en) begin
               e.pc   = m_pc;
               e.data = rom[m_pc[6:2]];
               q.push_back(e);
               m_pc = m_pc + 7'd4;
            end else begin
               m_stall = 1;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [6:0] rpc;
      for (int i = 0; i < 32; i++) rom[i] = $urandom;
      rst_n          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      @(negedge clk);
      do_reset();

      repeat (6) step(1, 0, '0);          // streaming from reset
      repeat (5) step(0, 0, '0);          // consumer stall fills buffer
      repeat (4) step(1, 0, '0);          // drain and resume
      repeat (2) step(0, 0, '0);
      step(0, 1, 7'd28);                  // aligned redirect with full buffer
      repeat (4) step(1, 0, '0);
      step(1, 1, 7'd124);                 // wrap past the top of the address space
      repeat (4) step(1, 0, '0);
      for (int i = 0; i < 12; i++) step(i[0], 0, '0);
      step(1, 1, 7'd30);                  // misaligned redirect
      for (int i = 0; i < 10; i++) step(1'($urandom), 1'($urandom), 7'($urandom));
      do_reset();
      repeat (4) step(1, 0, '0);
      repeat (3) step(0, 0, '0);
      do_reset();                         // mid-operation reset with buffered entries
      repeat (3) step(1, 0, '0);

      for (int i = 0; i < 3000; i++) begin
         if (m_fault && $urandom_range(0, 15) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            rpc = {5'($urandom_range(0, 31)), 2'b00};
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, rpc);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 7'd4: byte address of the first instruction fetched after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries when FETCH_PREFETCH_EN is defined; ignored otherwise.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rom_addr  output  7  byte address to instruction ROM (async-read, little-endian 32-bit word at addr..addr+3).
REQ-006 rom_en  output  1  ROM read enable; high only on cycles a fetch is issued.
REQ-007 rom_data  input  32  ROM read data, sampled same cycle as rom_addr/rom_en.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  7  redirect target byte address.
REQ-010 instr_valid  output  1  buffer head holds a valid instruction.
REQ-011 instr_ready  input  1  consumer accepts head this cycle.
REQ-012 instr  output  32  head instruction word.
REQ-013 instr_pc  output  7  byte address the head instruction was fetched from.
REQ-014 fault  output  1  sticky misaligned-redirect flag.

Function
REQ-015 FSM states: FETCH, STALL, FAULT; reset state FETCH.
REQ-016 FETCH: rom_en=1, rom_addr=pc; at the edge, {rom_data, pc} is pushed and pc <= pc+4 modulo 128 (7-bit wrap, 7'd124 -> 7'd0).
REQ-017 Fetch is issued only if the buffer is not full, or full with a pop in the same cycle; otherwise FSM goes to STALL.
REQ-018 STALL: rom_en=0, pc held; returns to FETCH on the cycle after a pop.
REQ-019 Pop occurs when instr_valid && instr_ready; instr_valid=(count!=0); instr/instr_pc show the head entry, zero when empty.
REQ-020 Push and pop in the same cycle leave count unchanged and preserve order.
REQ-021 Redirect has highest priority: with redirect_valid=1 and redirect_pc[1:0]==0, buffer flushes (count=0), pc <= redirect_pc, rom_en=0 that cycle, FSM -> FETCH; any same-cycle pop is discarded.
REQ-022 instr_valid is 0 the cycle after a redirect; the target instruction is valid on the following cycle.
REQ-023 Redirect with redirect_pc[1:0]!=0: FSM -> FAULT, fault=1, buffer flushed.
REQ-024 FAULT: rom_en=0, instr_valid=0, all inputs ignored; exits only via reset.
REQ-025 Steady-state throughput with instr_ready held high: one instruction per cycle, one-cycle fetch-to-valid latency.

Reset
REQ-026 rst_n low asynchronously forces: pc=RESET_PC, count=0, FSM=FETCH, fault=0, instr_valid=0, instr=0, instr_pc=0.
REQ-027 rom_en=0 while rst_n is low; the first fetch (rom_addr=RESET_PC) is issued in the first cycle after deassertion.
REQ-028 Reset asserted mid-operation discards all buffered instructions and clears fault.

Configuration
REQ-029 Macro FETCH_PREFETCH_EN defined: buffer is a DEPTH-entry FIFO; fetching continues while the consumer stalls until DEPTH entries are held.
REQ-030 Macro FETCH_PREFETCH_EN undefined: single-entry buffer; a fetch is issued only when empty or popped that cycle; all other behaviour identical.

Verification
REQ-031 ROM words at 4,8,12; release reset, instr_ready=1 -> instr_pc 4,8,12 on consecutive cycles, instr matching ROM.
REQ-032 Macro defined, DEPTH=2, instr_ready=0 -> two fetches (pc 4,8), then rom_en=0, STALL; ready=1 -> 4,8 delivered in order, fetch resumes at 12.
REQ-033 Redirect to 7'd28 while buffer holds 2 entries -> instr_valid=0 next cycle, then instr_pc=28 with ROM word at 28.
REQ-034 Redirect to 7'd30 -> fault=1, rom_en=0, instr_valid=0 held for 10 cycles; rst_n pulse -> fault=0, fetch restarts at 4.
REQ-035 Redirect to 7'd124, ready=1 -> instr_pc 124 then 0 (wrap).
REQ-036 Macro undefined, instr_ready toggling 1/0 -> rom_en never high while buffer full without pop; no instruction lost or duplicated.
